// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared core types, including store buffer entry types
package tartaruga_pkg;

  localparam int STORE_BUFFER_SIZE = 4;
  localparam int SB_IDX_W          = $clog2(STORE_BUFFER_SIZE);

  typedef logic [SB_IDX_W-1:0] store_buffer_idx_t;
  typedef logic [31:0]         bus32_t;
  typedef logic [1:0]          mem_size_t;

  localparam mem_size_t MEM_BYTE = 2'b00;
  localparam mem_size_t MEM_HALF = 2'b01;
  localparam mem_size_t MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_PENDING   = 2'd1,
    SB_COMMITTED = 2'd2
  } sb_state_t;

  typedef struct packed {
    sb_state_t state;
    bus32_t    addr;
    bus32_t    data;
    mem_size_t size;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// rtl/store_buffer_fwd.sv - age-ordered load/store word match over buffer entries
// Walks from oldest slot (tail) to youngest (tail-1) so the youngest match overrides.
module store_buffer_fwd
  import tartaruga_pkg::*;
#(
  parameter  int SB_SIZE = STORE_BUFFER_SIZE,
  localparam int IDX_W   = $clog2(SB_SIZE)
) (
  input  sb_entry_t         entries_i [SB_SIZE],
  input  logic [IDX_W-1:0]  tail_i,
  input  logic [31:0]       ld_addr_i,
  output logic              hit_o,
  output logic [31:0]       data_o,
  output logic              stall_o
);

  logic [IDX_W-1:0] idx;
  logic             unused_lo;

  always_comb begin
    hit_o     = 1'b0;
    data_o    = '0;
    stall_o   = 1'b0;
    idx       = '0;
    unused_lo = ^ld_addr_i[1:0];
    for (int k = 0; k < SB_SIZE; k++) begin
      idx       = tail_i + IDX_W'(k);
      unused_lo = unused_lo ^ (^entries_i[k].addr[1:0]);
      if (entries_i[idx].state != SB_FREE && entries_i[idx].addr[31:2] == ld_addr_i[31:2]) begin
        hit_o   = (entries_i[idx].size == MEM_WORD);
        stall_o = (entries_i[idx].size != MEM_WORD);
        data_o  = (entries_i[idx].size == MEM_WORD) ? entries_i[idx].data : '0;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer between MEM, ROB commit and data memory
// Optional load forwarding enabled by defining STORE_FWD_EN.
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter  int SB_SIZE = STORE_BUFFER_SIZE,
  parameter  int ADDR_W  = 32,
  localparam int IDX_W   = $clog2(SB_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [31:0]       alloc_data_i,
  input  logic [1:0]        alloc_size_i,
  output logic              alloc_ready_o,
  output logic [IDX_W-1:0]  alloc_idx_o,
  input  logic              commit_valid_i,
  input  logic [IDX_W-1:0]  commit_idx_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_data_o,
  output logic [1:0]        dmem_size_o,
  input  logic              dmem_ack_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic [31:0]       ld_data_o,
  output logic              ld_stall_o,
  output logic              empty_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  sb_entry_t        ent_q [SB_SIZE];
  sb_entry_t        ent_d [SB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d, n_cmt;
  logic [0:0]       st_q, st_d;
  logic             alloc_fire, drain_ack;

  assign alloc_ready_o = count_q < (IDX_W+1)'(SB_SIZE);
  assign alloc_idx_o   = tail_q;
  assign empty_o       = (count_q == '0);
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign drain_ack     = (st_q == ST_BUSY) & dmem_ack_i;

  // Commit and drain are applied before flush so committed stores always survive.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    count_d = count_q;
    st_d    = st_q;
    n_cmt   = '0;
    if (commit_valid_i) begin
      ent_d[cmt_q].state = SB_COMMITTED;
      cmt_d              = cmt_q + 1'b1;
    end
    if (drain_ack) begin
      ent_d[head_q].state = SB_FREE;
      head_d              = head_q + 1'b1;
    end
    if (flush_i) begin
      for (int i = 0; i < SB_SIZE; i++) begin
        if (ent_d[i].state == SB_PENDING) ent_d[i].state = SB_FREE;
        if (ent_d[i].state == SB_COMMITTED) n_cmt = n_cmt + 1'b1;
      end
      tail_d  = cmt_d;
      count_d = n_cmt;
    end else begin
      if (alloc_fire) begin
        ent_d[tail_q] = '{state: SB_PENDING, addr: alloc_addr_i, data: alloc_data_i, size: alloc_size_i};
        tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, drain_ack};
    end
    if (st_q == ST_IDLE || drain_ack)
      st_d = (ent_d[head_d].state == SB_COMMITTED) ? ST_BUSY : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_SIZE; i++)
        ent_q[i] <= '{state: SB_FREE, addr: '0, data: '0, size: '0};
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      st_q    <= ST_IDLE;
    end else begin
      assert (!commit_valid_i || (commit_idx_i == cmt_q && ent_q[cmt_q].state == SB_PENDING));
      ent_q   <= ent_d;
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      st_q    <= st_d;
    end
  end

  assign dmem_req_o  = (st_q == ST_BUSY);
  assign dmem_addr_o = dmem_req_o ? ent_q[head_q].addr : '0;
  assign dmem_data_o = dmem_req_o ? ent_q[head_q].data : '0;
  assign dmem_size_o = dmem_req_o ? ent_q[head_q].size : '0;

`ifdef STORE_FWD_EN
  store_buffer_fwd #(.SB_SIZE(SB_SIZE)) u_fwd (
    .entries_i (ent_q),
    .tail_i    (tail_q),
    .ld_addr_i (ld_addr_i),
    .hit_o     (ld_hit_o),
    .data_o    (ld_data_o),
    .stall_o   (ld_stall_o)
  );
`else
  logic unused_ld;
  assign unused_ld  = ^ld_addr_i;
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = '0;
  assign ld_stall_o = ~empty_o;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven self-checking bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid_i, commit_valid_i, flush_i, dmem_ack_i;
  logic [31:0] alloc_addr_i, alloc_data_i, ld_addr_i;
  logic [1:0]  alloc_size_i, commit_idx_i, alloc_idx_o;
  logic        alloc_ready_o, dmem_req_o, ld_hit_o, ld_stall_o, empty_o;
  logic [31:0] dmem_addr_o, dmem_data_o, ld_data_o;
  logic [1:0]  dmem_size_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .alloc_data_i(alloc_data_i),
    .alloc_size_i(alloc_size_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .commit_valid_i(commit_valid_i), .commit_idx_i(commit_idx_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
    .dmem_size_o(dmem_size_o), .dmem_ack_i(dmem_ack_i), .ld_addr_i(ld_addr_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o), .empty_o(empty_o)
  );

  typedef struct {
    logic        rst, av;
    logic [31:0] aa, ad;
    logic [1:0]  as;
    logic        cv;
    logic [1:0]  ci;
    logic        fl, ack;
    logic        e_rdy;
    logic [1:0]  e_idx;
    logic        e_req;
    logic [31:0] e_daddr, e_ddata;
    logic        e_empty;
    logic [31:0] la;
    logic        e_hit;
    logic [31:0] e_ldata;
    logic        e_fstall;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, input logic av, input logic [31:0] aa, input logic [31:0] ad,
                            input logic [1:0] as, input logic cv, input logic [1:0] ci, input logic fl,
                            input logic ack, input logic rdy, input logic [1:0] idx, input logic req,
                            input logic [31:0] da, input logic [31:0] dd, input logic emp,
                            input logic [31:0] la = 32'hFFFF_FFF0, input logic hit = 1'b0,
                            input logic [31:0] ld = 32'h0, input logic fst = 1'b0);
    vec_t t;
    t = '{r, av, aa, ad, as, cv, ci, fl, ack, rdy, idx, req, da, dd, emp, la, hit, ld, fst};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; alloc_valid_i = t.av; alloc_addr_i = t.aa; alloc_data_i = t.ad; alloc_size_i = t.as;
    commit_valid_i = t.cv; commit_idx_i = t.ci; flush_i = t.fl; dmem_ack_i = t.ack; ld_addr_i = t.la;
  endtask

  initial begin
    vec_t t, idle;
    logic exp_hit, exp_stall;
    logic [31:0] exp_ld;
    idle = '{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0,
             1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b0};
    // reset state
    v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,1);
    // single store: commit -> req next cycle, held until ack
    v(0,1,'h100,'hDEADBEEF,2, 0,0,0,0, 1,0,0,0,0,1);
    v(0,0,0,0,0, 1,0,0,0, 1,1,0,0,0,0);
    v(0,0,0,0,0, 0,0,0,0, 1,1,1,'h100,'hDEADBEEF,0);
    v(0,0,0,0,0, 0,0,0,0, 1,1,1,'h100,'hDEADBEEF,0);
    v(0,0,0,0,0, 0,0,0,1, 1,1,1,'h100,'hDEADBEEF,0);
    v(0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,1);
    v(1,0,0,0,0, 0,0,0,0, 1,1,0,0,0,1);
    // fill without commit; fifth alloc ignored
    v(0,1,'h300,'hA0,2, 0,0,0,0, 1,0,0,0,0,1);
    v(0,1,'h304,'hA1,2, 0,0,0,0, 1,1,0,0,0,0);
    v(0,1,'h308,'hA2,2, 0,0,0,0, 1,2,0,0,0,0);
    v(0,1,'h30C,'hA3,2, 0,0,0,0, 1,3,0,0,0,0);
    v(0,1,'h310,'hA4,2, 0,0,0,0, 0,0,0,0,0,0);
    v(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
    v(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
    // flush with same-cycle commit
    v(0,1,'h400,'hB0,2, 0,0,0,0, 1,0,0,0,0,1);
    v(0,1,'h404,'hB1,2, 0,0,0,0, 1,1,0,0,0,0);
    v(0,1,'h408,'hB2,2, 0,0,0,0, 1,2,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0, 1,3,0,0,0,0);
    v(0,0,0,0,0, 1,1,1,0, 1,3,1,'h400,'hB0,0);
    v(0,1,'h500,'hC0,2, 0,0,0,1, 1,2,1,'h400,'hB0,0);
    v(0,0,0,0,0, 0,0,0,1, 1,3,1,'h404,'hB1,0);
    v(0,0,0,0,0, 0,0,0,0, 1,3,0,0,0,0);
    v(1,0,0,0,0, 0,0,0,0, 1,3,0,0,0,0);
    // back-to-back drain with wrap
    v(0,1,'h600,'hD0,2, 0,0,0,0, 1,0,0,0,0,1);
    v(0,1,'h604,'hD1,2, 0,0,0,0, 1,1,0,0,0,0);
    v(0,1,'h608,'hD2,2, 0,0,0,0, 1,2,0,0,0,0);
    v(0,1,'h60C,'hD3,2, 0,0,0,0, 1,3,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0);
    v(0,0,0,0,0, 1,1,0,1, 0,0,1,'h600,'hD0,0);
    v(0,0,0,0,0, 1,2,0,1, 1,0,1,'h604,'hD1,0);
    v(0,0,0,0,0, 1,3,0,1, 1,0,1,'h608,'hD2,0);
    v(0,0,0,0,0, 0,0,0,1, 1,0,1,'h60C,'hD3,0);
    v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,1);
    // reset while a write is outstanding
    v(0,1,'h700,'hE0,2, 0,0,0,0, 1,0,0,0,0,1);
    v(0,0,0,0,0, 1,0,0,0, 1,1,0,0,0,0);
    v(0,0,0,0,0, 0,0,0,0, 1,1,1,'h700,'hE0,0);
    v(1,0,0,0,0, 0,0,0,0, 1,1,1,'h700,'hE0,0);
    v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,1);
    // load forwarding / conservative stall
    v(0,1,'h200,'h11111111,2, 0,0,0,0, 1,0,0,0,0,1, 'h202,0,0,0);
    v(0,1,'h200,'h22222222,2, 0,0,0,0, 1,1,0,0,0,0, 'h202,1,'h11111111,0);
    v(0,0,0,0,0,              0,0,0,0, 1,2,0,0,0,0, 'h202,1,'h22222222,0);
    v(0,1,'h204,'h33,0,       0,0,0,0, 1,2,0,0,0,0, 'h202,1,'h22222222,0);
    v(0,0,0,0,0,              0,0,0,0, 1,3,0,0,0,0, 'h204,0,0,1);
    v(0,0,0,0,0,              0,0,0,0, 1,3,0,0,0,0, 'h208,0,0,0);
    v(1,0,0,0,0, 0,0,0,0, 1,3,0,0,0,0);
    v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,1);

    t = idle;
    t.rst = 1'b1;
    drive(t);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      t = vecs[i];
      drive(t);
      #1;
`ifdef STORE_FWD_EN
      exp_hit = t.e_hit; exp_ld = t.e_ldata; exp_stall = t.e_fstall;
`else
      exp_hit = 1'b0; exp_ld = 32'h0; exp_stall = ~t.e_empty;
`endif
      chk("alloc_ready", i, {31'h0, alloc_ready_o}, {31'h0, t.e_rdy});
      chk("alloc_idx",   i, {30'h0, alloc_idx_o},   {30'h0, t.e_idx});
      chk("dmem_req",    i, {31'h0, dmem_req_o},    {31'h0, t.e_req});
      chk("dmem_addr",   i, dmem_addr_o, t.e_daddr);
      chk("dmem_data",   i, dmem_data_o, t.e_ddata);
      chk("dmem_size",   i, {30'h0, dmem_size_o},   t.e_req ? 32'd2 : 32'd0);
      chk("empty",       i, {31'h0, empty_o},       {31'h0, t.e_empty});
      chk("ld_hit",      i, {31'h0, ld_hit_o},      {31'h0, exp_hit});
      chk("ld_data",     i, ld_data_o, exp_ld);
      chk("ld_stall",    i, {31'h0, ld_stall_o},    {31'h0, exp_stall});
    end

    // alloc coinciding with flush is discarded
    @(negedge clk);
    t = idle; t.av = 1'b1; t.aa = 32'h800; t.ad = 32'hF0; t.as = 2'd2; t.fl = 1'b1;
    drive(t);
    @(negedge clk);
    drive(idle);
    #1;
    chk("flush_alloc_empty", 999, {31'h0, empty_o}, 32'd1);
    chk("flush_alloc_idx",   999, {30'h0, alloc_idx_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("flush_alloc_noreq", 999, {31'h0, dmem_req_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
